levinson_durbin_control: RTL and testbench

Sequencing FSM for the order-10 Levinson-Durbin recursion in the LPC datapath. After reset it runs autonomously, once: initialise error energy, then for each order i = 1..ORDER accumulate reflection numerator q, load k, update predictor coefficients through a temp bank, write a[i] and update e. All outputs are registered one-hot selects and load strobes to the shared arithmetic datapath. It then idles until the next reset.

---
 rtl/levinson_durbin_control_pkg.sv | 34 +++
 rtl/levinson_durbin_control.sv | 196 +++++++++++++++++++
 tb/tb_levinson_durbin_control.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/levinson_durbin_control_pkg.sv
// Shared definitions for the order-10 Levinson-Durbin sequencing FSM:
// prediction order, derived select widths, state encoding and one-hot helper.
package levinson_durbin_control_pkg;

    localparam int ORDER = 10;
    localparam int R_W   = ORDER + 1;
    localparam int A_W   = ORDER;
    localparam int T_W   = ORDER - 1;
    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] ORDER_C = CNT_W'(ORDER);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        QACC,
        KLD,
        UPD,
        WB,
        FIN,
        DONE
    } state_e;

    // Indices at or beyond width give an all-zero vector, so a stray index never selects.
    function automatic logic [R_W-1:0] onehot(input logic [CNT_W-1:0] index, input int width);
        logic [R_W-1:0] v;
        v = '0;
        for (int n = 0; n < R_W; n++) begin
            v[n] = (n < width) && (index == CNT_W'(n));
        end
        return v;
    endfunction

endpackage

// File: rtl/levinson_durbin_control.sv
// Sequencer for the Levinson-Durbin recursion: runs once after reset, driving
// registered one-hot selects and load strobes into the shared arithmetic datapath.
module levinson_durbin_control
    import levinson_durbin_control_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    output logic [R_W-1:0] r_rsel_o,
    output logic [A_W-1:0] a_rsel_o,
    output logic [A_W-1:0] a_wsel_o,
    output logic [T_W-1:0] temp_sel_o,
    output logic           out_sel_o,
    output logic           e_sel_o,
    output logic           q_sel_o,
    output logic           k_load_o,
    output logic           e_load_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] i_q, i_d;
    logic [CNT_W-1:0] j_q, j_d;
    logic             j_last_s;
    logic [CNT_W-1:0] i_minus_j_s;

    logic [R_W-1:0] r_rsel_q, r_rsel_d;
    logic [A_W-1:0] a_rsel_q, a_rsel_d;
    logic [A_W-1:0] a_wsel_q, a_wsel_d;
    logic [T_W-1:0] temp_sel_q, temp_sel_d;
    logic           out_sel_q, out_sel_d;
    logic           e_sel_q, e_sel_d;
    logic           q_sel_q, q_sel_d;
    logic           k_load_q, k_load_d;
    logic           e_load_q, e_load_d;

    assign j_last_s    = (j_q == (i_q - 4'd1));
    assign i_minus_j_s = i_d - j_d;

    // Next-state and i/j counter sequencing
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                state_d = INIT;
                i_d     = 4'd0;
                j_d     = 4'd0;
            end
            INIT: begin
                state_d = QACC;
                i_d     = 4'd1;
                j_d     = 4'd0;
            end
            QACC: begin
                if (j_last_s) begin
                    state_d = KLD;
                end else begin
                    j_d = j_q + 4'd1;
                end
            end
            KLD: begin
                j_d = 4'd1;
                if (i_q > 4'd1) begin
                    state_d = UPD;
                end else begin
                    state_d = FIN;
                end
            end
            UPD: begin
                if (j_last_s) begin
                    state_d = WB;
                    j_d     = 4'd1;
                end else begin
                    j_d = j_q + 4'd1;
                end
            end
            WB: begin
                if (j_last_s) begin
                    state_d = FIN;
                end else begin
                    j_d = j_q + 4'd1;
                end
            end
            FIN: begin
                if (i_q == ORDER_C) begin
                    state_d = DONE;
                end else begin
                    state_d = QACC;
                    i_d     = i_q + 4'd1;
                    j_d     = 4'd0;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                i_d     = 4'd0;
                j_d     = 4'd0;
            end
        endcase
    end

    // Decode from the state being entered, so the output register holds that state's selects
    always_comb begin
        r_rsel_d   = '0;
        a_rsel_d   = '0;
        a_wsel_d   = '0;
        temp_sel_d = '0;
        out_sel_d  = 1'b0;
        e_sel_d    = 1'b0;
        q_sel_d    = 1'b0;
        k_load_d   = 1'b0;
        e_load_d   = 1'b0;
        case (state_d)
            INIT: begin
                r_rsel_d = onehot(4'd0, R_W);
                e_load_d = 1'b1;
            end
            QACC: begin
                if (j_d == 4'd0) begin
                    r_rsel_d = onehot(i_d, R_W);
                    q_sel_d  = 1'b0;
                end else begin
                    r_rsel_d = onehot(i_minus_j_s, R_W);
                    a_rsel_d = A_W'(onehot(j_d - 4'd1, A_W));
                    q_sel_d  = 1'b1;
                end
            end
            KLD: begin
                k_load_d = 1'b1;
            end
            UPD: begin
                a_rsel_d   = A_W'(onehot(i_minus_j_s - 4'd1, A_W));
                temp_sel_d = T_W'(onehot(j_d - 4'd1, T_W));
            end
            WB: begin
                a_rsel_d   = A_W'(onehot(j_d - 4'd1, A_W));
                temp_sel_d = T_W'(onehot(j_d - 4'd1, T_W));
                a_wsel_d   = A_W'(onehot(j_d - 4'd1, A_W));
                out_sel_d  = 1'b0;
            end
            FIN: begin
                a_wsel_d  = A_W'(onehot(i_d - 4'd1, A_W));
                out_sel_d = 1'b1;
                e_sel_d   = 1'b1;
                e_load_d  = 1'b1;
            end
            default: begin
                r_rsel_d = '0;
            end
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            i_q        <= 4'd0;
            j_q        <= 4'd0;
            r_rsel_q   <= '0;
            a_rsel_q   <= '0;
            a_wsel_q   <= '0;
            temp_sel_q <= '0;
            out_sel_q  <= 1'b0;
            e_sel_q    <= 1'b0;
            q_sel_q    <= 1'b0;
            k_load_q   <= 1'b0;
            e_load_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            r_rsel_q   <= r_rsel_d;
            a_rsel_q   <= a_rsel_d;
            a_wsel_q   <= a_wsel_d;
            temp_sel_q <= temp_sel_d;
            out_sel_q  <= out_sel_d;
            e_sel_q    <= e_sel_d;
            q_sel_q    <= q_sel_d;
            k_load_q   <= k_load_d;
            e_load_q   <= e_load_d;
        end
    end

    assign r_rsel_o   = r_rsel_q;
    assign a_rsel_o   = a_rsel_q;
    assign a_wsel_o   = a_wsel_q;
    assign temp_sel_o = temp_sel_q;
    assign out_sel_o  = out_sel_q;
    assign e_sel_o    = e_sel_q;
    assign q_sel_o    = q_sel_q;
    assign k_load_o   = k_load_q;
    assign e_load_o   = e_load_q;

endmodule

// File: tb/tb_levinson_durbin_control.sv
// Scoreboard bench for levinson_durbin_control: a driver pushes the expected
// per-cycle output vector, a negedge monitor pops and compares.
module tb_levinson_durbin_control;

    typedef struct packed {
        logic [10:0] r;
        logic [9:0]  a;
        logic [9:0]  w;
        logic [8:0]  t;
        logic        os;
        logic        es;
        logic        qs;
        logic        kl;
        logic        el;
    } vec_t;

    typedef struct {
        vec_t v;
        int   cyc;
        bit   cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [10:0] r_rsel;
    logic [9:0]  a_rsel;
    logic [9:0]  a_wsel;
    logic [8:0]  temp_sel;
    logic        out_sel, e_sel, q_sel, k_load, e_load;
    vec_t        act;

    exp_t exp_q[$];
    vec_t seq[$];
    vec_t hand[int];
    int   n_cmp;
    int   n_err;
    int   kl_cnt;
    int   el_cnt;

    levinson_durbin_control dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .r_rsel_o   (r_rsel),
        .a_rsel_o   (a_rsel),
        .a_wsel_o   (a_wsel),
        .temp_sel_o (temp_sel),
        .out_sel_o  (out_sel),
        .e_sel_o    (e_sel),
        .q_sel_o    (q_sel),
        .k_load_o   (k_load),
        .e_load_o   (e_load)
    );

    assign act = {r_rsel, a_rsel, a_wsel, temp_sel, out_sel, e_sel, q_sel, k_load, e_load};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // r: r index or -1; a/w/t: 1-based coefficient/temp number or 0 for none
    function automatic vec_t mk(input int r, input int a, input int w, input int t,
                                input logic [4:0] f);
        vec_t        v;
        logic [15:0] x;
        v = '0;
        x = '0; if (r >= 0) x[r] = 1'b1;   v.r = x[10:0];
        x = '0; if (a > 0)  x[a-1] = 1'b1; v.a = x[9:0];
        x = '0; if (w > 0)  x[w-1] = 1'b1; v.w = x[9:0];
        x = '0; if (t > 0)  x[t-1] = 1'b1; v.t = x[8:0];
        {v.os, v.es, v.qs, v.kl, v.el} = f;
        return v;
    endfunction

    function automatic vec_t hv(input logic [10:0] r, input logic [9:0] a, input logic [9:0] w,
                                input logic [8:0] t, input logic [4:0] f);
        return {r, a, w, t, f};
    endfunction

    task automatic build_seq();
        seq.push_back(mk(0, 0, 0, 0, 5'b00001));
        for (int i = 1; i <= 10; i++) begin
            for (int j = 0; j < i; j++) begin
                if (j == 0) seq.push_back(mk(i, 0, 0, 0, 5'b00000));
                else        seq.push_back(mk(i - j, j, 0, 0, 5'b00100));
            end
            seq.push_back(mk(-1, 0, 0, 0, 5'b00010));
            for (int j = 1; j < i; j++) seq.push_back(mk(-1, i - j, 0, j, 5'b00000));
            for (int j = 1; j < i; j++) seq.push_back(mk(-1, j, j, j, 5'b00000));
            seq.push_back(mk(-1, 0, i, 0, 5'b11001));
        end
    endtask

    task automatic check_vec(input string name, input int cyc, input vec_t got, input vec_t want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h required %h", name, cyc, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic push(input vec_t v, input int cyc, input bit cnt);
        exp_t e;
        e.v   = v;
        e.cyc = cyc;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    function automatic vec_t expect_at(input int c);
        vec_t z;
        z = '0;
        if (c <= seq.size()) return seq[c-1];
        return z;
    endfunction

    // Monitor: pops one expectation per cycle and checks invariants
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check_vec("seq", e.cyc, act, e.v);
                if (e.cyc > 0 && hand.exists(e.cyc)) check_vec("hand", e.cyc, act, hand[e.cyc]);
                n_cmp++;
                if (!($onehot0(act.r) && $onehot0(act.a) && $onehot0(act.w) && $onehot0(act.t)
                      && !(act.w != 10'h000 && act.kl) && !(act.kl && act.el))) begin
                    n_err++;
                    $display("FAIL invariants cycle %0d: got %h", e.cyc, act);
                end
                if (e.cnt) begin
                    kl_cnt += int'(act.kl);
                    el_cnt += int'(act.el);
                end
            end
        end
    end

    // Driver: reset, full run, restart, mid-run reset, replay
    initial begin
        vec_t zero;
        zero   = '0;
        n_cmp  = 0;
        n_err  = 0;
        kl_cnt = 0;
        el_cnt = 0;
        build_seq();
        hand[1]   = hv(11'h001, 10'h000, 10'h000, 9'h000, 5'b00001);
        hand[2]   = hv(11'h002, 10'h000, 10'h000, 9'h000, 5'b00000);
        hand[3]   = hv(11'h000, 10'h000, 10'h000, 9'h000, 5'b00010);
        hand[4]   = hv(11'h000, 10'h000, 10'h001, 9'h000, 5'b11001);
        hand[5]   = hv(11'h004, 10'h000, 10'h000, 9'h000, 5'b00000);
        hand[6]   = hv(11'h002, 10'h001, 10'h000, 9'h000, 5'b00100);
        hand[7]   = hv(11'h000, 10'h000, 10'h000, 9'h000, 5'b00010);
        hand[8]   = hv(11'h000, 10'h001, 10'h000, 9'h001, 5'b00000);
        hand[9]   = hv(11'h000, 10'h001, 10'h001, 9'h001, 5'b00000);
        hand[10]  = hv(11'h000, 10'h000, 10'h002, 9'h000, 5'b11001);
        hand[166] = hv(11'h000, 10'h000, 10'h200, 9'h000, 5'b11001);
        hand[167] = hv(11'h000, 10'h000, 10'h000, 9'h000, 5'b00000);

        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            push(zero, 0, 1'b0);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 226; c++) begin
            @(posedge clk); #1;
            push(expect_at(c), c, 1'b1);
        end
        @(negedge clk); #1;
        check_int("k_load_pulses", kl_cnt, 10);
        check_int("e_load_pulses", el_cnt, 11);

        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        push(zero, 0, 1'b0);
        rst_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            push(expect_at(c), c, 1'b0);
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_reset", 40, act, zero);
        @(posedge clk); #1;
        push(zero, 0, 1'b0);
        rst_n = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            push(expect_at(c), c, 1'b0);
        end
        @(negedge clk); #1;
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
